// File: rtl/mm2s_dest_tagger.sv
// Pairs each MM2S command tag with its data packet, tags both streams with the decoded destination,
// drops dest==3 packets and counts per-dest packets. Optional output skid slice: MM2S_DEST_TAGGER_OREG_EN.
module mm2s_dest_tagger #(
  parameter int AXI_DATA_WIDTH = 128,
  parameter int MM2S_TAG_WIDTH = 64,
  parameter int DEST_LSB       = 0,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  output logic                          s_axis_mm2s_tready,
  input  logic                          s_axis_mm2s_tvalid,
  input  logic [AXI_DATA_WIDTH-1:0]     s_axis_mm2s_tdata,
  input  logic [AXI_DATA_WIDTH/8-1:0]   s_axis_mm2s_tkeep,
  input  logic                          s_axis_mm2s_tlast,
  output logic                          s_axis_mm2s_tag_tready,
  input  logic                          s_axis_mm2s_tag_tvalid,
  input  logic [MM2S_TAG_WIDTH-1:0]     s_axis_mm2s_tag_tdata,
  input  logic [MM2S_TAG_WIDTH/8-1:0]   s_axis_mm2s_tag_tkeep,
  input  logic                          s_axis_mm2s_tag_tlast,
  input  logic                          m_axis_buf2int_tready,
  output logic                          m_axis_buf2int_tvalid,
  output logic [AXI_DATA_WIDTH-1:0]     m_axis_buf2int_tdata,
  output logic [AXI_DATA_WIDTH/8-1:0]   m_axis_buf2int_tkeep,
  output logic                          m_axis_buf2int_tlast,
  output logic [1:0]                    m_axis_buf2int_tdest,
  input  logic                          m_axis_buf2int_tag_tready,
  output logic                          m_axis_buf2int_tag_tvalid,
  output logic [MM2S_TAG_WIDTH-1:0]     m_axis_buf2int_tag_tdata,
  output logic [MM2S_TAG_WIDTH/8-1:0]   m_axis_buf2int_tag_tkeep,
  output logic                          m_axis_buf2int_tag_tlast,
  output logic [1:0]                    m_axis_buf2int_tag_tdest,
  output logic                          err_bad_dest,
  output logic [CNT_WIDTH-1:0]          pkt_cnt_pe,
  output logic [CNT_WIDTH-1:0]          pkt_cnt_bn,
  output logic [CNT_WIDTH-1:0]          pkt_cnt_res
);

  localparam int ADW = AXI_DATA_WIDTH;
  localparam int TW  = MM2S_TAG_WIDTH;

  typedef enum logic [1:0] {IDLE, SEND_TAG, STREAM, DROP} state_t;

  state_t                 state_q, state_d;
  logic [TW-1:0]          tag_dat_q;
  logic [TW/8-1:0]        tag_keep_q;
  logic                   tag_last_q;
  logic [1:0]             dest_q;
  logic                   err_q;
  logic [CNT_WIDTH-1:0]   cnt_pe_q, cnt_bn_q, cnt_res_q;

  logic       tag_fire, m_tag_fire, fwd_fire, drop_fire, slice_empty;
  logic [1:0] tag_dest;

  assign tag_dest               = s_axis_mm2s_tag_tdata[DEST_LSB +: 2];
  assign s_axis_mm2s_tag_tready = !rst && (state_q == IDLE);
  assign tag_fire               = s_axis_mm2s_tag_tvalid && s_axis_mm2s_tag_tready;
  assign m_tag_fire             = m_axis_buf2int_tag_tvalid && m_axis_buf2int_tag_tready;
  assign fwd_fire  = (state_q == STREAM) && s_axis_mm2s_tvalid && s_axis_mm2s_tready;
  assign drop_fire = (state_q == DROP) && s_axis_mm2s_tvalid && s_axis_mm2s_tready;

  // The tag is held back until any previous packet has fully left the output slice.
  assign m_axis_buf2int_tag_tvalid = (state_q == SEND_TAG) && slice_empty;
  assign m_axis_buf2int_tag_tdata  = tag_dat_q;
  assign m_axis_buf2int_tag_tkeep  = tag_keep_q;
  assign m_axis_buf2int_tag_tlast  = tag_last_q;
  assign m_axis_buf2int_tag_tdest  = dest_q;

  assign err_bad_dest = err_q;
  assign pkt_cnt_pe   = cnt_pe_q;
  assign pkt_cnt_bn   = cnt_bn_q;
  assign pkt_cnt_res  = cnt_res_q;

`ifdef MM2S_DEST_TAGGER_OREG_EN
  typedef struct packed {
    logic [ADW-1:0]   dat;
    logic [ADW/8-1:0] keep;
    logic             last;
    logic [1:0]       dest;
  } beat_t;

  beat_t in_beat, out_q, skid_q;
  logic  out_vld_q, skid_vld_q;

  assign in_beat            = '{dat: s_axis_mm2s_tdata, keep: s_axis_mm2s_tkeep,
                                last: s_axis_mm2s_tlast, dest: dest_q};
  assign slice_empty        = !out_vld_q && !skid_vld_q;
  assign s_axis_mm2s_tready = !rst && (((state_q == STREAM) && !skid_vld_q) || (state_q == DROP));

  assign m_axis_buf2int_tvalid = out_vld_q;
  assign m_axis_buf2int_tdata  = out_q.dat;
  assign m_axis_buf2int_tkeep  = out_q.keep;
  assign m_axis_buf2int_tlast  = out_q.last;
  assign m_axis_buf2int_tdest  = out_q.dest;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_vld_q  <= 1'b0;
      skid_vld_q <= 1'b0;
      out_q      <= '0;
      skid_q     <= '0;
    end else if (!out_vld_q || m_axis_buf2int_tready) begin
      if (skid_vld_q) begin
        out_q      <= skid_q;
        out_vld_q  <= 1'b1;
        skid_vld_q <= 1'b0;
      end else begin
        out_vld_q <= fwd_fire;
        if (fwd_fire) out_q <= in_beat;
      end
    end else if (fwd_fire) begin
      skid_q     <= in_beat;
      skid_vld_q <= 1'b1;
    end
  end
`else
  assign slice_empty        = 1'b1;
  assign s_axis_mm2s_tready = !rst && (((state_q == STREAM) && m_axis_buf2int_tready) ||
                                       (state_q == DROP));

  assign m_axis_buf2int_tvalid = (state_q == STREAM) && s_axis_mm2s_tvalid;
  assign m_axis_buf2int_tdata  = s_axis_mm2s_tdata;
  assign m_axis_buf2int_tkeep  = s_axis_mm2s_tkeep;
  assign m_axis_buf2int_tlast  = s_axis_mm2s_tlast;
  assign m_axis_buf2int_tdest  = dest_q;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (tag_fire) state_d = (tag_dest == 2'b11) ? DROP : SEND_TAG;
      SEND_TAG: if (m_tag_fire) state_d = STREAM;
      STREAM:   if (fwd_fire && s_axis_mm2s_tlast) state_d = IDLE;
      DROP:     if (drop_fire && s_axis_mm2s_tlast) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      tag_dat_q  <= '0;
      tag_keep_q <= '0;
      tag_last_q <= 1'b0;
      dest_q     <= 2'b00;
      err_q      <= 1'b0;
      cnt_pe_q   <= '0;
      cnt_bn_q   <= '0;
      cnt_res_q  <= '0;
    end else begin
      state_q <= state_d;
      if (tag_fire) begin
        tag_dat_q  <= s_axis_mm2s_tag_tdata;
        tag_keep_q <= s_axis_mm2s_tag_tkeep;
        tag_last_q <= s_axis_mm2s_tag_tlast;
        dest_q     <= tag_dest;
        if (tag_dest == 2'b11) err_q <= 1'b1;
      end
      // A packet counts once its last beat has been accepted from upstream.
      if (fwd_fire && s_axis_mm2s_tlast) begin
        case (dest_q)
          2'b00:   cnt_pe_q  <= cnt_pe_q + CNT_WIDTH'(1);
          2'b01:   cnt_bn_q  <= cnt_bn_q + CNT_WIDTH'(1);
          2'b10:   cnt_res_q <= cnt_res_q + CNT_WIDTH'(1);
          default: ;
        endcase
      end
    end
  end

endmodule
